rram_op_sequencer: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle RRAM instruction decoder.
- Accepts one 32-bit array instruction per valid/ready handshake.
- Decodes it to one-hot WL/BL/SL selects.
- Sequences the analog periphery through timed phases: write pulse, or precharge then sense/ADC.
- Returns a single-cycle response with read data or an error flag.
- Sits between the host instruction queue and the RRAM array periphery (drivers, VSA/CSA, ADC).

---
 rtl/rram_op_sequencer.sv | 172 +++++++++++++++++
 tb/tb_rram_op_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rram_op_sequencer.sv
// rram_op_sequencer: accepts RRAM array instructions and sequences the periphery through timed write/read phases.
module rram_op_sequencer #(
  parameter int INSTR_W = 32,
  parameter int ARRAY_ROWS = 16,
  parameter int ARRAY_COLS = 16,
  parameter int ROW_AW = 4,
  parameter int COL_AW = 4,
  parameter int ADC_W = 4,
  parameter int WR_PULSE = 4,
  parameter int PRE_CYC = 2,
  parameter int SENSE_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic instr_valid,
  output logic instr_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic [ARRAY_ROWS-1:0] wl_sel,
  output logic [ARRAY_COLS-1:0] bl_sel,
  output logic [ARRAY_COLS-1:0] sl_sel,
  output logic enable_wl,
  output logic enable_bl,
  output logic enable_sl,
  output logic drive_set,
  output logic pre,
  output logic saen_vsa,
  output logic saen_csa,
  output logic clk_en_adc,
  input  logic sa_in,
  input  logic [ADC_W-1:0] adc_in,
  output logic rsp_valid,
  output logic rsp_err,
  output logic [ADC_W-1:0] rsp_data,
  output logic busy
);
  localparam int MX = WR_PULSE > PRE_CYC ? (WR_PULSE > SENSE_CYC ? WR_PULSE : SENSE_CYC)
                                         : (PRE_CYC > SENSE_CYC ? PRE_CYC : SENSE_CYC);
  localparam int CW = $clog2(MX) + 1;
  localparam logic [3:0] OP_NOP = 4'h0, OP_SET = 4'h8, OP_RST = 4'h9;
  localparam logic [3:0] OP_VSA = 4'h1, OP_CSA = 4'h2, OP_ADC = 4'h3;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, RECOVER, PRECH, SENSE, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] op;
  logic [3:0] opc;
  logic [ROW_AW-1:0] row;
  logic [COL_AW-1:0] col;
  logic wr, rd, bad, unused_bits;
  assign opc = instruction[INSTR_W-1 -: 4];
  assign row = instruction[COL_AW+ROW_AW-1:COL_AW];
  assign col = instruction[COL_AW-1:0];
  assign wr = opc == OP_SET || opc == OP_RST;
  assign rd = opc == OP_VSA || opc == OP_CSA || opc == OP_ADC;
  assign bad = !(wr || rd || opc == OP_NOP) || 32'(row) >= ARRAY_ROWS || 32'(col) >= ARRAY_COLS;
  assign unused_bits = ^instruction[INSTR_W-5:COL_AW+ROW_AW];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      instr_ready <= 1'b0;
      busy <= 1'b0;
      wl_sel <= '0;
      bl_sel <= '0;
      sl_sel <= '0;
      enable_wl <= 1'b0;
      enable_bl <= 1'b0;
      enable_sl <= 1'b0;
      drive_set <= 1'b0;
      pre <= 1'b0;
      saen_vsa <= 1'b0;
      saen_csa <= 1'b0;
      clk_en_adc <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_data <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            op <= opc;
            instr_ready <= 1'b0;
            busy <= 1'b1;
            if (bad || opc == OP_NOP) begin
              state <= DONE;
              rsp_valid <= 1'b1;
              rsp_err <= bad;
              rsp_data <= '0;
            end else begin
              state <= SETUP;
              wl_sel <= ARRAY_ROWS'(1) << row;
              bl_sel <= ARRAY_COLS'(1) << col;
              sl_sel <= wr ? ARRAY_COLS'(1) << col : '0;
              drive_set <= opc == OP_SET;
            end
          end else begin
            instr_ready <= 1'b1;
          end
        end
        // only legal write/read opcodes reach SETUP, so op[3] alone marks a write
        SETUP: begin
          if (op[3]) begin
            state <= PULSE;
            cnt <= CW'(WR_PULSE - 1);
            enable_sl <= 1'b1;
          end else begin
            state <= PRECH;
            cnt <= CW'(PRE_CYC - 1);
            pre <= 1'b1;
          end
          enable_wl <= 1'b1;
          enable_bl <= 1'b1;
        end
        PULSE: begin
          if (cnt == '0) begin
            state <= RECOVER;
            enable_wl <= 1'b0;
            enable_bl <= 1'b0;
            enable_sl <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RECOVER: begin
          state <= DONE;
          rsp_valid <= 1'b1;
          rsp_data <= '0;
          wl_sel <= '0;
          bl_sel <= '0;
          sl_sel <= '0;
          drive_set <= 1'b0;
        end
        PRECH: begin
          if (cnt == '0) begin
            state <= SENSE;
            cnt <= CW'(SENSE_CYC - 1);
            pre <= 1'b0;
            saen_vsa <= op == OP_VSA;
            saen_csa <= op == OP_CSA;
            clk_en_adc <= op == OP_ADC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SENSE: begin
          if (cnt == '0) begin
            state <= DONE;
            rsp_valid <= 1'b1;
            rsp_data <= op == OP_ADC ? adc_in : ADC_W'(sa_in);
            wl_sel <= '0;
            bl_sel <= '0;
            enable_wl <= 1'b0;
            enable_bl <= 1'b0;
            saen_vsa <= 1'b0;
            saen_csa <= 1'b0;
            clk_en_adc <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          instr_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rram_op_sequencer.sv
// tb_rram_op_sequencer: randomized and directed checks of rram_op_sequencer against a transaction-level model.
module tb_rram_op_sequencer;
  localparam int WR = 4, PRE = 2, SEN = 3;
  typedef struct packed {
    logic [7:0] lat;
    logic [15:0] wl, bl, sl;
    logic [7:0] en_wl, en_bl, en_sl, pre, vsa, csa, adc;
    logic ds, err;
    logic [3:0] data;
    logic [7:0] rsp_cnt, rdy_busy, stray, done_act;
  } txn_t;
  logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, sa_in = 1'b0;
  logic [31:0] instruction = '0;
  logic [3:0] adc_in = '0;
  logic instr_ready, enable_wl, enable_bl, enable_sl, drive_set, pre, saen_vsa, saen_csa, clk_en_adc;
  logic rsp_valid, rsp_err, busy;
  logic [15:0] wl_sel, bl_sel, sl_sel;
  logic [3:0] rsp_data;
  logic b_instr_ready, b_enable_wl, b_enable_bl, b_enable_sl, b_drive_set, b_pre, b_saen_vsa, b_saen_csa;
  logic b_clk_en_adc, b_rsp_valid, b_rsp_err, b_busy;
  logic [11:0] b_wl_sel;
  logic [15:0] b_bl_sel, b_sl_sel;
  logic [3:0] b_rsp_data;
  logic [63:0] all_out;
  int passed = 0, total = 0;
  txn_t o;
  int brk, wait_n;
  logic b_v1, b_e1, b_sel;
  logic [3:0] b_d1;
  assign all_out = {wl_sel, bl_sel, sl_sel, enable_wl, enable_bl, enable_sl, drive_set, pre, saen_vsa,
                    saen_csa, clk_en_adc, rsp_valid, rsp_err, rsp_data, busy, instr_ready};
  always #5 clk = ~clk;

  rram_op_sequencer #(.INSTR_W(32), .ARRAY_ROWS(16), .ARRAY_COLS(16), .ROW_AW(4), .COL_AW(4), .ADC_W(4),
    .WR_PULSE(WR), .PRE_CYC(PRE), .SENSE_CYC(SEN)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
    .wl_sel(wl_sel), .bl_sel(bl_sel), .sl_sel(sl_sel), .enable_wl(enable_wl), .enable_bl(enable_bl),
    .enable_sl(enable_sl), .drive_set(drive_set), .pre(pre), .saen_vsa(saen_vsa), .saen_csa(saen_csa),
    .clk_en_adc(clk_en_adc), .sa_in(sa_in), .adc_in(adc_in), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .busy(busy));

  rram_op_sequencer #(.INSTR_W(32), .ARRAY_ROWS(12), .ARRAY_COLS(16), .ROW_AW(4), .COL_AW(4), .ADC_W(4),
    .WR_PULSE(WR), .PRE_CYC(PRE), .SENSE_CYC(SEN)) dut12 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(b_instr_ready), .instruction(instruction),
    .wl_sel(b_wl_sel), .bl_sel(b_bl_sel), .sl_sel(b_sl_sel), .enable_wl(b_enable_wl), .enable_bl(b_enable_bl),
    .enable_sl(b_enable_sl), .drive_set(b_drive_set), .pre(b_pre), .saen_vsa(b_saen_vsa), .saen_csa(b_saen_csa),
    .clk_en_adc(b_clk_en_adc), .sa_in(sa_in), .adc_in(adc_in), .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err),
    .rsp_data(b_rsp_data), .busy(b_busy));

  // lat is the sampling slot (1 = the cycle right after acceptance) in which rsp_valid is seen
  function automatic txn_t model(input logic [31:0] ins, input int rows, input logic sa, input logic [3:0] adc);
    txn_t e;
    logic [3:0] op;
    int r, c;
    bit w, rd, bad;
    op = ins[31:28];
    r = int'(ins[7:4]);
    c = int'(ins[3:0]);
    w = op == 4'h8 || op == 4'h9;
    rd = op >= 4'h1 && op <= 4'h3;
    bad = !(w || rd || op == 4'h0) || r >= rows || c >= 16;
    e = '0;
    e.rsp_cnt = 8'd1;
    if (bad || op == 4'h0) begin
      e.lat = 8'd1;
      e.err = bad;
    end else if (w) begin
      e.lat = 8'(WR + 3);
      e.wl = 16'(1) << r;
      e.bl = 16'(1) << c;
      e.sl = e.bl;
      e.en_wl = 8'(WR);
      e.en_bl = 8'(WR);
      e.en_sl = 8'(WR);
      e.ds = op == 4'h8;
    end else begin
      e.lat = 8'(2 + PRE + SEN);
      e.wl = 16'(1) << r;
      e.bl = 16'(1) << c;
      e.en_wl = 8'(PRE + SEN);
      e.en_bl = 8'(PRE + SEN);
      e.pre = 8'(PRE);
      e.vsa = op == 4'h1 ? 8'(SEN) : 8'd0;
      e.csa = op == 4'h2 ? 8'(SEN) : 8'd0;
      e.adc = op == 4'h3 ? 8'(SEN) : 8'd0;
      e.data = op == 4'h3 ? adc : {3'b000, sa};
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] ins, input bit keep, input logic [31:0] nxt);
    int n;
    instruction = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    wait_n = n;
    @(posedge clk);
    #1;
    if (keep) instruction = nxt;
    else instr_valid = 1'b0;
    o = '0;
    brk = 0;
    b_sel = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      o.wl |= wl_sel;
      o.bl |= bl_sel;
      o.sl |= sl_sel;
      o.en_wl += 8'(enable_wl);
      o.en_bl += 8'(enable_bl);
      o.en_sl += 8'(enable_sl);
      o.pre += 8'(pre);
      o.vsa += 8'(saen_vsa);
      o.csa += 8'(saen_csa);
      o.adc += 8'(clk_en_adc);
      o.ds |= drive_set;
      if (busy && instr_ready) o.rdy_busy++;
      if (rsp_err && !rsp_valid) o.stray++;
      if (rsp_valid) begin
        o.rsp_cnt++;
        if (|{wl_sel, bl_sel, sl_sel, enable_wl, enable_bl, enable_sl, pre, saen_vsa, saen_csa, clk_en_adc})
          o.done_act++;
        if (o.lat == 0) begin
          o.lat = 8'(c);
          o.err = rsp_err;
          o.data = rsp_data;
        end
      end
      if (c == 1) begin
        b_v1 = b_rsp_valid;
        b_e1 = b_rsp_err;
        b_d1 = b_rsp_data;
      end
      b_sel |= |{b_wl_sel, b_bl_sel, b_sl_sel, b_enable_wl, b_enable_bl, b_enable_sl};
      if (o.lat != 0 && c > int'(o.lat) && !busy) begin
        brk = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    instruction = 32'h8000_0015;
    instr_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, instr_ready} !== 2'b01) $display("FAIL reset_release: busy/ready got %b want 01", {busy, instr_ready});
    else passed++;
    instr_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, rsp_valid, instr_ready} !== 3'b001) $display("FAIL reset_no_accept: got %b want 001", {busy, rsp_valid, instr_ready});
    else passed++;
  endtask

  task automatic test_write();
    txn_t e;
    logic [31:0] ins [2] = '{32'h8000_0015, 32'h9000_00E3};
    for (int i = 0; i < 2; i++) begin
      e = model(ins[i], 16, sa_in, adc_in);
      issue(ins[i], 1'b0, '0);
      total++;
      if (o !== e) $display("FAIL write_%0d: got %p want %p", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_read();
    txn_t e;
    logic [31:0] ins [3] = '{32'h3000_0027, 32'h1000_0015, 32'h2000_00F0};
    logic sas [3] = '{1'b0, 1'b1, 1'b1};
    logic [3:0] adcs [3] = '{4'hA, 4'h5, 4'h6};
    for (int i = 0; i < 3; i++) begin
      sa_in = sas[i];
      adc_in = adcs[i];
      e = model(ins[i], 16, sa_in, adc_in);
      issue(ins[i], 1'b0, '0);
      total++;
      if (o !== e) $display("FAIL read_%0d: got %p want %p", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    txn_t e;
    e = model(32'hF000_00BA, 16, sa_in, adc_in);
    issue(32'hF000_00BA, 1'b0, '0);
    total++;
    if (o !== e) $display("FAIL illegal_op: got %p want %p", o, e);
    else passed++;
    e = model(32'h0000_0000, 16, sa_in, adc_in);
    issue(32'h0000_0000, 1'b0, '0);
    total++;
    if (o !== e) $display("FAIL nop: got %p want %p", o, e);
    else passed++;
    sa_in = 1'b1;
    e = model(32'h1000_00DA, 16, sa_in, adc_in);
    issue(32'h1000_00DA, 1'b0, '0);
    total++;
    if (o !== e) $display("FAIL row13_16rows: got %p want %p", o, e);
    else passed++;
    total++;
    if ({b_v1, b_e1, b_d1} !== 6'b110000) $display("FAIL row13_12rows_rsp: valid/err/data got %b want 110000", {b_v1, b_e1, b_d1});
    else passed++;
    total++;
    if (b_sel !== 1'b0) $display("FAIL row13_12rows_selects: got %b want 0", b_sel);
    else passed++;
  endtask

  task automatic test_back_to_back();
    txn_t ew, er;
    adc_in = 4'h3;
    ew = model(32'h8000_0042, 16, sa_in, adc_in);
    er = model(32'h3000_0071, 16, sa_in, adc_in);
    issue(32'h8000_0042, 1'b1, 32'h3000_0071);
    total++;
    if (o !== ew) $display("FAIL b2b_write: got %p want %p", o, ew);
    else passed++;
    total++;
    if (brk !== int'(ew.lat) + 1) $display("FAIL b2b_ready_return: got slot %0d want %0d", brk, int'(ew.lat) + 1);
    else passed++;
    issue(32'h3000_0071, 1'b0, '0);
    total++;
    if (wait_n !== 0) $display("FAIL b2b_accept_gap: got extra wait %0d want 0", wait_n);
    else passed++;
    total++;
    if (o !== er) $display("FAIL b2b_read: got %p want %p", o, er);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int rv;
    instruction = 32'h8000_0015;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (enable_wl !== 1'b1) $display("FAIL mid_pulse_active: enable_wl got %b want 1", enable_wl);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (all_out !== '0) $display("FAIL mid_reset_outputs: got %h want 0", all_out);
    else passed++;
    rst = 1'b0;
    rv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rv += int'(rsp_valid);
    end
    total++;
    if ({rv, busy, instr_ready} !== {32'd0, 2'b01}) $display("FAIL mid_reset_abort: rsp count %0d busy %b ready %b want 0 0 1", rv, busy, instr_ready);
    else passed++;
  endtask

  task automatic test_random();
    txn_t e;
    logic [3:0] ops [9] = '{4'h0, 4'h8, 4'h9, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 4'hA};
    logic [31:0] rnd, ins;
    for (int i = 0; i < 16; i++) begin
      rnd = $urandom();
      ins = {ops[$urandom_range(0, 8)], rnd[27:0]};
      sa_in = 1'($urandom_range(0, 1));
      adc_in = 4'($urandom_range(0, 15));
      e = model(ins, 16, sa_in, adc_in);
      issue(ins, 1'b0, '0);
      total++;
      if (o !== e) $display("FAIL random_%0d ins=%h: got %p want %p", i, ins, o, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end
endmodule
